midi_note_parser: RTL and testbench
===================================

MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 Parameter: VEL0_IS_OFF, default 1, Note On with velocity 0 reports as note_off when 1, as note_on when 0.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: byte_rdy  input  1  one-cycle strobe; byte_in is valid this cycle.
REQ-005 Port: byte_in  input  8  received MIDI byte.
REQ-006 Port: channel  input  4  MIDI channel to accept (0-15); sampled on each status byte.
REQ-007 Port: note_on  output  1  one-cycle pulse, Note On decoded.
REQ-008 Port: note_off  output  1  one-cycle pulse, Note Off decoded.
REQ-009 Port: note  output  7  key number of the last decoded note event; held between events.
REQ-010 Port: velocity  output  7  velocity of the last decoded note event; held between events.

Function
REQ-011 FSM states SHALL be IDLE (no status), D1 (expect first data byte), D2 (expect second data byte), SKIP (discard data bytes).
REQ-012 Only cycles with byte_rdy=1 SHALL advance the FSM; with byte_rdy=0, state and outputs hold, except that pulses deassert.
REQ-013 On byte_in 0xF8-0xFF (realtime), the block SHALL leave state, running status and outputs unchanged.
REQ-014 On byte_in 0xF0-0xF7, the block SHALL clear running status and go to SKIP with msg_len=0, discarding data until the next status.
REQ-015 On status 0x8n/0x9n with n==channel, the block SHALL latch the status and go to D1.
REQ-016 On any other channel status (0x80-0xEF), the block SHALL go to SKIP.
REQ-017 In SKIP, msg_len SHALL be 1 for 0xCn/0xDn and 2 otherwise, so running-status data stays in byte alignment.
REQ-018 On a data byte (bit7=0) in D1, the block SHALL store it as the key and go to D2.
REQ-019 On a data byte in D2, the block SHALL complete the event and update note/velocity, with the corresponding pulse high in the cycle after the byte_rdy strobe (latency 1).
REQ-020 Completed 0x8n SHALL pulse note_off; 0x9n with velocity>0 SHALL pulse note_on; 0x9n with velocity 0 SHALL pulse note_off if VEL0_IS_OFF=1, else note_on.
REQ-021 note_on and note_off SHALL never be high in the same cycle.
REQ-022 A data byte in IDLE SHALL be ignored.
REQ-023 A status byte arriving in D1 or D2 SHALL abort the partial message without a pulse and be decoded as a new status.
REQ-024 A channel change SHALL affect only status bytes received afterwards.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set state=IDLE, clear running status, and set note_on=0, note_off=0, note=0, velocity=0.
REQ-026 Reset SHALL take priority over byte_rdy in the same cycle.
REQ-027 Reset mid-message SHALL drop the partial message, and the following data bytes SHALL be ignored.

Configuration
REQ-028 Macro MIDI_RUNNING_STATUS_EN SHALL select running-status support.
REQ-029 With MIDI_RUNNING_STATUS_EN defined, after D2 completes or a SKIP message ends, the FSM SHALL return to D1 or SKIP under the retained status, so further data byte pairs decode without a new status.
REQ-030 Without MIDI_RUNNING_STATUS_EN, after any completed or skipped message the FSM SHALL return to IDLE, and data bytes without a fresh status SHALL be ignored.

Verification
REQ-031 channel=0; bytes 0x90,0x3C,0x64 -> one note_on pulse 1 cycle after the third strobe, note=0x3C, velocity=0x64.
REQ-032 channel=0; bytes 0x90,0x3C,0x00 with VEL0_IS_OFF=1 -> note_off pulse, note=0x3C, velocity=0; with VEL0_IS_OFF=0 -> note_on pulse.
REQ-033 channel=0; bytes 0x90,0x3C,0xF8,0x64 -> a single note_on pulse with note=0x3C, velocity=0x64; the realtime byte causes no disturbance.
REQ-034 channel=0; bytes 0x91,0x40,0x40 then 0xC0,0x05 then 0x80,0x40,0x00 -> only one pulse, note_off with note=0x40.
REQ-035 MIDI_RUNNING_STATUS_EN defined; bytes 0x90,0x3C,0x64,0x3E,0x50 -> two note_on pulses (0x3C/0x64, then 0x3E/0x50); macro undefined -> only the first pulse.
REQ-036 rst after bytes 0x90,0x3C, then bytes 0x64,0x40 -> no pulse; all outputs 0.

Source files
------------

// File: rtl/midi_note_parser.sv
// midi_note_parser: decodes Note On/Off messages for one MIDI channel; define MIDI_RUNNING_STATUS_EN for running-status support
module midi_note_parser #(
  parameter bit VEL0_IS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_rdy,
  input  logic [7:0] byte_in,
  input  logic [3:0] channel,
  output logic       note_on,
  output logic       note_off,
  output logic [6:0] note,
  output logic [6:0] velocity
);
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, D1, D2, SKIP} state_t;
  state_t state, state_nx;
  logic       on_st, on_st_nx;
  logic [1:0] msg_len, msg_len_nx, cnt, cnt_nx;
  logic [6:0] key, key_nx, note_nx, velocity_nx;
  logic       note_on_nx, note_off_nx;
  logic       status, data, fire, last;
  assign status = byte_rdy && byte_in[7] && byte_in < 8'hF8;
  assign data   = byte_rdy && !byte_in[7];
  assign fire   = data && state == D2;
  assign last   = cnt + 2'd1 == msg_len;
  // State and datapath registers; reset drops any partial message and running status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      on_st    <= 1'b0;
      msg_len  <= 2'd0;
      cnt      <= 2'd0;
      key      <= 7'd0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      note     <= 7'd0;
      velocity <= 7'd0;
    end else begin
      state    <= state_nx;
      on_st    <= on_st_nx;
      msg_len  <= msg_len_nx;
      cnt      <= cnt_nx;
      key      <= key_nx;
      note_on  <= note_on_nx;
      note_off <= note_off_nx;
      note     <= note_nx;
      velocity <= velocity_nx;
    end
  end
  // Next state: status bytes always restart decoding; data bytes walk the message, skipped messages are counted to keep alignment
  always_comb begin
    state_nx   = state;
    on_st_nx   = on_st;
    msg_len_nx = msg_len;
    cnt_nx     = cnt;
    key_nx     = key;
    if (status) begin
      cnt_nx     = 2'd0;
      on_st_nx   = byte_in[4];
      msg_len_nx = byte_in[7:4] == 4'hF ? 2'd0 : byte_in[7:5] == 3'b110 ? 2'd1 : 2'd2;
      state_nx   = byte_in[7:5] == 3'b100 && byte_in[3:0] == channel ? D1 : SKIP;
    end else if (data && state == D1) begin
      key_nx   = byte_in[6:0];
      state_nx = D2;
    end else if (fire) begin
      state_nx = RS ? D1 : IDLE;
    end else if (data && state == SKIP && msg_len != 2'd0) begin
      cnt_nx   = last ? 2'd0 : cnt + 2'd1;
      state_nx = last && !RS ? IDLE : SKIP;
    end
  end
  // Outputs: one-cycle pulse on a completed note message, note/velocity held until the next one
  always_comb begin
    note_on_nx  = fire && on_st && (byte_in[6:0] != 7'd0 || !VEL0_IS_OFF);
    note_off_nx = fire && !(on_st && (byte_in[6:0] != 7'd0 || !VEL0_IS_OFF));
    note_nx     = fire ? key : note;
    velocity_nx = fire ? byte_in[6:0] : velocity;
  end
endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser: message-level model plus directed and random byte streams for midi_note_parser
module tb_midi_note_parser;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, byte_rdy = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [3:0] channel = 4'd0;
  logic note_on, note_off, note_on0, note_off0;
  logic [6:0] note, velocity, note0, velocity0;
  int errors = 0, checks = 0;
  logic [7:0] m_st = 8'h00;
  logic m_match = 1'b0;
  int m_n = 0;
  logic [6:0] m_d0 = 7'd0, e_note = 7'd0, e_vel = 7'd0;
  logic e_on = 1'b0, e_off = 1'b0, e_on0 = 1'b0, e_off0 = 1'b0;
  logic lit_en = 1'b0, l_on, l_off, l_on0, l_off0;
  logic [6:0] l_note, l_vel;
  string lit_name;

  always #5 clk = ~clk;

  midi_note_parser dut (.clk(clk), .rst(rst), .byte_rdy(byte_rdy), .byte_in(byte_in), .channel(channel),
    .note_on(note_on), .note_off(note_off), .note(note), .velocity(velocity));
  midi_note_parser #(.VEL0_IS_OFF(1'b0)) dut0 (.clk(clk), .rst(rst), .byte_rdy(byte_rdy), .byte_in(byte_in),
    .channel(channel), .note_on(note_on0), .note_off(note_off0), .note(note0), .velocity(velocity0));

  // Message-level model: current status (0 = none), channel match taken at status time, data bytes collected
  always @(posedge clk) begin
    e_on <= 1'b0; e_off <= 1'b0; e_on0 <= 1'b0; e_off0 <= 1'b0;
    if (rst) begin
      m_st <= 8'h00; m_n <= 0; e_note <= 7'd0; e_vel <= 7'd0;
    end else if (byte_rdy && byte_in[7] && byte_in < 8'hF8) begin
      m_st <= byte_in < 8'hF0 ? byte_in : 8'h00;
      m_match <= byte_in[3:0] == channel;
      m_n <= 0;
    end else if (byte_rdy && !byte_in[7] && m_st != 8'h00) begin
      if (m_n + 1 < ((m_st[7:4] == 4'hC || m_st[7:4] == 4'hD) ? 1 : 2)) begin
        m_n <= m_n + 1; m_d0 <= byte_in[6:0];
      end else begin
        m_n <= 0;
        if (!RS) m_st <= 8'h00;
        if (m_match && (m_st[7:4] == 4'h8 || m_st[7:4] == 4'h9)) begin
          e_note <= m_d0; e_vel <= byte_in[6:0];
          e_on <= m_st[7:4] == 4'h9 && byte_in != 8'h00;
          e_off <= m_st[7:4] == 4'h8 || byte_in == 8'h00;
          e_on0 <= m_st[7:4] == 4'h9;
          e_off0 <= m_st[7:4] == 4'h8;
        end
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Compare process: model every cycle, hand-computed literals when armed
  always @(negedge clk) begin
    chk("note_on", int'(note_on), int'(e_on));
    chk("note_off", int'(note_off), int'(e_off));
    chk("note", int'(note), int'(e_note));
    chk("velocity", int'(velocity), int'(e_vel));
    chk("note_on_v0", int'(note_on0), int'(e_on0));
    chk("note_off_v0", int'(note_off0), int'(e_off0));
    chk("note_v0", int'(note0), int'(e_note));
    chk("velocity_v0", int'(velocity0), int'(e_vel));
    chk("exclusive", int'(note_on & note_off), 0);
    if (lit_en) begin
      chk({lit_name, ".on"}, int'(note_on), int'(l_on));
      chk({lit_name, ".off"}, int'(note_off), int'(l_off));
      chk({lit_name, ".on_v0"}, int'(note_on0), int'(l_on0));
      chk({lit_name, ".off_v0"}, int'(note_off0), int'(l_off0));
      chk({lit_name, ".note"}, int'(note), int'(l_note));
      chk({lit_name, ".vel"}, int'(velocity), int'(l_vel));
    end
  end

  task automatic send(input logic [7:0] b);
    byte_in = b; byte_rdy = 1'b1;
    @(posedge clk); #1 byte_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_rst(input logic rdy, input logic [7:0] b);
    rst = 1'b1; byte_rdy = rdy; byte_in = b;
    @(posedge clk); #1 rst = 1'b0; byte_rdy = 1'b0;
  endtask

  task automatic expect_now(input string n, input logic on, input logic off, input logic on0,
                            input logic off0, input logic [6:0] nt, input logic [6:0] vl);
    lit_name = n; l_on = on; l_off = off; l_on0 = on0; l_off0 = off0; l_note = nt; l_vel = vl;
    lit_en = 1'b1;
    @(negedge clk); #1 lit_en = 1'b0;
  endtask

  initial begin
    do_rst(1'b0, 8'h00);
    expect_now("reset", 0, 0, 0, 0, 7'h00, 7'h00);
    send(8'h90); send(8'h3C); send(8'h64);
    expect_now("on_basic", 1, 0, 1, 0, 7'h3C, 7'h64);
    idle(1);
    expect_now("hold", 0, 0, 0, 0, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); send(8'h00);
    expect_now("vel0", 0, 1, 1, 0, 7'h3C, 7'h00);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    expect_now("realtime", 1, 0, 1, 0, 7'h3C, 7'h64);
    send(8'h91); send(8'h40); send(8'h40);
    expect_now("other_ch", 0, 0, 0, 0, 7'h3C, 7'h64);
    send(8'hC0); send(8'h05); send(8'h80); send(8'h40); send(8'h00);
    expect_now("note_off", 0, 1, 0, 1, 7'h40, 7'h00);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    if (RS) expect_now("running", 1, 0, 1, 0, 7'h3E, 7'h50);
    else expect_now("no_running", 0, 0, 0, 0, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); do_rst(1'b1, 8'h64); send(8'h64); send(8'h40);
    expect_now("rst_mid", 0, 0, 0, 0, 7'h00, 7'h00);
    channel = 4'd5;
    send(8'h95); send(8'h10); channel = 4'd3; send(8'h20);
    expect_now("ch_latched", 1, 0, 1, 0, 7'h10, 7'h20);
    send(8'h95); send(8'h11); send(8'h96); send(8'h12); send(8'h7F);
    expect_now("ch_mismatch", 0, 0, 0, 0, 7'h10, 7'h20);
    channel = 4'd5;
    send(8'h95); send(8'h11); send(8'h85); send(8'h12); send(8'h7F);
    expect_now("abort", 0, 1, 0, 1, 7'h12, 7'h7F);
    send(8'hF0); send(8'h95 & 8'h7F); send(8'h02); send(8'h03); send(8'hF7); send(8'h22); send(8'h33);
    expect_now("sysex", 0, 0, 0, 0, 7'h12, 7'h7F);
    send(8'h95); send(8'h13); send(8'h00);
    expect_now("after_sysex", 0, 1, 1, 0, 7'h13, 7'h00);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 3) channel = 4'($urandom_range(0, 1));
      b = r < 20 ? {4'($urandom_range(8, 9)), 4'($urandom_range(0, 1))} :
          r < 26 ? 8'($urandom_range(8'hA0, 8'hEF)) :
          r < 29 ? 8'($urandom_range(8'hF0, 8'hF7)) :
          r < 32 ? 8'($urandom_range(8'hF8, 8'hFF)) :
          r < 38 ? 8'h00 : 8'($urandom_range(1, 127));
      if (r == 94) do_rst(1'($urandom_range(0, 1)), b);
      else if (r >= 95) idle(1);
      else send(b);
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
